corewriscv_axi4_routed_bus: RTL and testbench

COREWRISCV_AXI4_ROUTED_BUS -- requirements
Module: coreriscv_axi4_routed_bus

---
 rtl/corewriscv_axi4_routed_bus_if.sv | 35 +++
 rtl/corewriscv_axi4_routed_bus.sv | 160 ++++++++++++++++
 tb/tb_corewriscv_axi4_routed_bus.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/corewriscv_axi4_routed_bus_if.sv
// Bus bundle for the routed bus: N_IN request channels in, one shared
// response bus out with a one-hot per-output valid.
//   master : traffic side (drives in_* and out_ready, sees in_ready and out_*)
//   slave  : router side (the opposite directions)
interface corewriscv_axi4_routed_bus_if #(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 4,
  parameter int DST_W     = 2,
  parameter int PAYLOAD_W = 28
);
  localparam int SRC_W = $clog2(N_IN);

  logic [N_IN-1:0]           in_valid;
  logic [N_IN-1:0]           in_ready;
  logic [N_IN*DST_W-1:0]     in_dst;
  logic [N_IN-1:0]           in_last;
  logic [N_IN*PAYLOAD_W-1:0] in_payload;

  logic [N_OUT-1:0]          out_valid;
  logic [N_OUT-1:0]          out_ready;
  logic [SRC_W-1:0]          out_src;
  logic [DST_W-1:0]          out_dst;
  logic                      out_last;
  logic [PAYLOAD_W-1:0]      out_payload;

  modport master (
    output in_valid, in_dst, in_last, in_payload, out_ready,
    input  in_ready, out_valid, out_src, out_dst, out_last, out_payload
  );

  modport slave (
    input  in_valid, in_dst, in_last, in_payload, out_ready,
    output in_ready, out_valid, out_src, out_dst, out_last, out_payload
  );
endinterface

// File: rtl/corewriscv_axi4_routed_bus.sv
// Routed bus: round-robin arbiter with message locking in front of a
// one-entry output slot that drives a shared out_* bus with one-hot valid.
//   clk, reset  : single clock, asynchronous active-low reset
//   bus (slave) : in_valid/in_ready/in_dst/in_last/in_payload per input,
//                 out_valid (one-hot)/out_ready per output, shared
//                 out_src/out_dst/out_last/out_payload
//   chosen      : currently granted input
//   err_bad_dst : one-cycle pulse after a beat with dst >= N_OUT was dropped

// Per-output lane: decodes the slot destination into this output's valid
// and reports whether this output drains the slot.
module corewriscv_axi4_routed_bus_olane #(
  parameter int DST_W = 2,
  parameter int IDX   = 0
) (
  input  logic             full,
  input  logic [DST_W-1:0] dst,
  input  logic             rdy,
  output logic             vld,
  output logic             drn
);
  assign vld = full && (int'(dst) == IDX);
  assign drn = vld && rdy;
endmodule

module corewriscv_axi4_routed_bus #(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 4,
  parameter int DST_W     = 2,
  parameter int PAYLOAD_W = 28
) (
  input  logic                     clk,
  input  logic                     reset,
  corewriscv_axi4_routed_bus_if.slave bus,
  output logic [$clog2(N_IN)-1:0]  chosen,
  output logic                     err_bad_dst
);
  localparam int SRC_W = $clog2(N_IN);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  typedef struct packed {
    logic [SRC_W-1:0]     src;
    logic [DST_W-1:0]     dst;
    logic                 last;
    logic [PAYLOAD_W-1:0] payload;
  } slot_t;

  logic [N_IN-1:0][DST_W-1:0]     dst_v;
  logic [N_IN-1:0][PAYLOAD_W-1:0] pay_v;

  logic [0:0]       lock_st;
  logic [SRC_W-1:0] rr_ptr;
  logic             slot_full;
  slot_t            slot;

  logic [SRC_W-1:0] rr_idx;
  logic [SRC_W-1:0] cand;
  logic             found;
  logic [SRC_W-1:0] g;
  logic             gnt_any;
  logic [N_OUT-1:0] vld_v;
  logic [N_OUT-1:0] drn_v;
  logic             drain;
  logic             rdy_ok;
  logic             accept;
  logic             acc_legal;
  logic             acc_last;

  assign dst_v = bus.in_dst;
  assign pay_v = bus.in_payload;

  // Round-robin search: first valid input strictly after rr_ptr, wrapping.
  // With nothing valid the pointer itself is reported.
  always_comb begin
    rr_idx = rr_ptr;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_IN; k++) begin
      cand = SRC_W'((int'(rr_ptr) + k) % N_IN);
      if (!found && bus.in_valid[cand]) begin
        found  = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // While locked, rr_ptr already holds the locked input: only it can be
  // accepted, and every acceptance rewrites rr_ptr with the granted index.
  assign g       = (lock_st == ST_LOCKED) ? rr_ptr : rr_idx;
  assign gnt_any = (lock_st == ST_LOCKED) || found;

  for (genvar k = 0; k < N_OUT; k++) begin : g_olane
    corewriscv_axi4_routed_bus_olane #(
      .DST_W (DST_W),
      .IDX   (k)
    ) u_olane (
      .full (slot_full),
      .dst  (slot.dst),
      .rdy  (bus.out_ready[k]),
      .vld  (vld_v[k]),
      .drn  (drn_v[k])
    );
  end

  assign drain  = |drn_v;
  assign rdy_ok = reset && gnt_any && (!slot_full || drain);

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N_IN; i++)
      bus.in_ready[i] = rdy_ok && (g == SRC_W'(i));
  end

  assign accept    = bus.in_valid[g] && rdy_ok;
  assign acc_legal = int'(dst_v[g]) < N_OUT;
  assign acc_last  = bus.in_last[g];

  // chosen reads 0 while reset is held even though rr_ptr resets to N_IN-1.
  assign chosen = reset ? g : '0;

  assign bus.out_valid   = vld_v;
  assign bus.out_src     = slot.src;
  assign bus.out_dst     = slot.dst;
  assign bus.out_last    = slot.last;
  assign bus.out_payload = slot.payload;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_full   <= 1'b0;
      slot        <= '0;
      lock_st     <= ST_IDLE;
      rr_ptr      <= SRC_W'(N_IN - 1);
      err_bad_dst <= 1'b0;
    end else begin
      err_bad_dst <= accept && !acc_legal;

      // Load wins over drain so a drain+accept cycle refills with no bubble.
      // An illegal beat is consumed but never reaches the slot.
      if (accept && acc_legal) begin
        slot_full    <= 1'b1;
        slot.src     <= g;
        slot.dst     <= dst_v[g];
        slot.last    <= acc_last;
        slot.payload <= pay_v[g];
      end else if (drain) begin
        slot_full <= 1'b0;
      end

      if (accept) rr_ptr <= g;

      case (lock_st)
        ST_IDLE:   if (accept && !acc_last) lock_st <= ST_LOCKED;
        ST_LOCKED: if (accept && acc_last)  lock_st <= ST_IDLE;
        default:   lock_st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_corewriscv_axi4_routed_bus.sv
module tb_corewriscv_axi4_routed_bus;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // a: defaults, b: three outputs (dst 3 illegal), c: wide random config
  corewriscv_axi4_routed_bus_if #(.N_IN(4), .N_OUT(4), .DST_W(2), .PAYLOAD_W(28)) ba ();
  corewriscv_axi4_routed_bus_if #(.N_IN(4), .N_OUT(3), .DST_W(2), .PAYLOAD_W(28)) bb ();
  corewriscv_axi4_routed_bus_if #(.N_IN(8), .N_OUT(2), .DST_W(1), .PAYLOAD_W(64)) bc ();

  logic [1:0] cho_a, cho_b;
  logic [2:0] cho_c;
  logic       err_a, err_b, err_c;

  corewriscv_axi4_routed_bus #(.N_IN(4), .N_OUT(4), .DST_W(2), .PAYLOAD_W(28)) dut_a (
    .clk(clk), .reset(reset), .bus(ba), .chosen(cho_a), .err_bad_dst(err_a));
  corewriscv_axi4_routed_bus #(.N_IN(4), .N_OUT(3), .DST_W(2), .PAYLOAD_W(28)) dut_b (
    .clk(clk), .reset(reset), .bus(bb), .chosen(cho_b), .err_bad_dst(err_b));
  corewriscv_axi4_routed_bus #(.N_IN(8), .N_OUT(2), .DST_W(1), .PAYLOAD_W(64)) dut_c (
    .clk(clk), .reset(reset), .bus(bc), .chosen(cho_c), .err_bad_dst(err_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic set_a(input int i, input bit v, input logic [1:0] d, input bit l, input logic [27:0] p);
    ba.in_valid[i] = v;
    ba.in_dst[i*2 +: 2] = d;
    ba.in_last[i] = l;
    ba.in_payload[i*28 +: 28] = p;
  endtask

  task automatic set_b(input int i, input bit v, input logic [1:0] d, input bit l, input logic [27:0] p);
    bb.in_valid[i] = v;
    bb.in_dst[i*2 +: 2] = d;
    bb.in_last[i] = l;
    bb.in_payload[i*28 +: 28] = p;
  endtask

  task automatic clear_inputs;
    ba.in_valid = '0; ba.in_dst = '0; ba.in_last = '0; ba.in_payload = '0; ba.out_ready = '0;
    bb.in_valid = '0; bb.in_dst = '0; bb.in_last = '0; bb.in_payload = '0; bb.out_ready = '0;
    bc.in_valid = '0; bc.in_dst = '0; bc.in_last = '0; bc.in_payload = '0; bc.out_ready = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // random-test model state
  int sent[8], rcvd[8], left[8];
  bit v[8];
  logic dstm[8];
  int open_src;
  logic [7:0] acc;
  logic [63:0] pl;
  int s;
  bit done;

  initial begin
    clear_inputs();
    reset = 1'b0;
    step();
    // reset state, with inputs requesting to prove gating
    ba.in_valid = 4'b1000;
    #1;
    chk("rst_out_valid", ba.out_valid, 0);
    chk("rst_in_ready", ba.in_ready, 0);
    chk("rst_chosen", cho_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_out_src", ba.out_src, 0);
    chk("rst_out_payload", ba.out_payload, 0);

    // round robin across four always-valid inputs
    do_reset();
    for (int i = 0; i < 4; i++) set_a(i, 1, 2'd0, 1, 28'h100 + 28'(i));
    ba.out_ready = 4'b0001;
    #1;
    chk("rr_lat0_valid", ba.out_valid, 0);
    chk("rr_first_ready", ba.in_ready, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rr_valid", ba.out_valid, 4'b0001);
      chk("rr_src", ba.out_src, c % 4);
      chk("rr_payload", ba.out_payload, 28'h100 + 28'(c % 4));
      chk("rr_ready", ba.in_ready, 4'b0001 << ((c + 1) % 4));
    end

    // 4-beat locked message from input 1 while input 0 waits
    do_reset();
    ba.out_ready = 4'hF;
    set_a(1, 1, 2'd2, 0, 28'd1);
    #1;
    chk("lock_first_chosen", cho_a, 1);
    for (int b = 2; b <= 4; b++) begin
      step();
      set_a(1, 1, 2'd2, (b == 4), 28'(b));
      set_a(0, 1, 2'd1, 1, 28'hAA);
      #1;
      chk("lock_src", ba.out_src, 1);
      chk("lock_valid", ba.out_valid, 4'b0100);
      chk("lock_payload", ba.out_payload, 28'(b - 1));
      chk("lock_chosen", cho_a, 1);
      chk("lock_ready", ba.in_ready, 4'b0010);
    end
    step();
    set_a(1, 0, 2'd0, 0, 28'd0);
    #1;
    chk("lock_b4_src", ba.out_src, 1);
    chk("lock_b4_last", ba.out_last, 1);
    chk("lock_b4_payload", ba.out_payload, 4);
    chk("lock_rel_chosen", cho_a, 0);
    step();
    chk("lock_next_src", ba.out_src, 0);
    chk("lock_next_valid", ba.out_valid, 4'b0010);
    chk("lock_next_payload", ba.out_payload, 28'hAA);

    // backpressure on output 3, then drain and accept in one cycle
    do_reset();
    ba.out_ready = 4'b0111;
    set_a(2, 1, 2'd3, 1, 28'hA1);
    #1;
    chk("bp_first_ready", ba.in_ready, 4'b0100);
    step();
    set_a(2, 1, 2'd0, 1, 28'hB2);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready_low", ba.in_ready, 0);
      chk("bp_valid", ba.out_valid, 4'b1000);
      chk("bp_payload", ba.out_payload, 28'hA1);
      chk("bp_dst", ba.out_dst, 3);
      step();
    end
    ba.out_ready = 4'hF;
    #1;
    chk("bp_drain_ready", ba.in_ready, 4'b0100);
    chk("bp_drain_valid", ba.out_valid, 4'b1000);
    step();
    set_a(2, 0, 2'd0, 0, 28'd0);
    #1;
    chk("bp_nobubble_valid", ba.out_valid, 4'b0001);
    chk("bp_nobubble_payload", ba.out_payload, 28'hB2);
    step();
    chk("bp_empty", ba.out_valid, 0);

    // illegal destination on the three-output instance
    do_reset();
    bb.out_ready = 3'b111;
    set_b(2, 1, 2'd3, 1, 28'd1);
    #1;
    chk("bad_ready", bb.in_ready, 4'b0100);
    chk("bad_err_pre", err_b, 0);
    step();
    set_b(2, 0, 2'd0, 0, 28'd0);
    #1;
    chk("bad_no_valid", bb.out_valid, 0);
    chk("bad_err_pulse", err_b, 1);
    step();
    set_b(1, 1, 2'd3, 0, 28'd2);
    #1;
    chk("bad_err_drop", err_b, 0);
    chk("bad_no_valid2", bb.out_valid, 0);
    chk("bad_lock_ready", bb.in_ready, 4'b0010);
    step();
    set_b(1, 1, 2'd1, 1, 28'd3);
    set_b(0, 1, 2'd0, 1, 28'd4);
    #1;
    chk("bad_locked_chosen", cho_b, 1);
    chk("bad_err_again", err_b, 1);
    chk("bad_locked_ready", bb.in_ready, 4'b0010);
    step();
    set_b(1, 0, 2'd0, 0, 28'd0);
    #1;
    chk("bad_after_valid", bb.out_valid, 3'b010);
    chk("bad_after_src", bb.out_src, 1);
    chk("bad_after_payload", bb.out_payload, 3);
    chk("bad_after_chosen", cho_b, 0);
    step();
    set_b(0, 0, 2'd0, 0, 28'd0);
    #1;
    chk("bad_final_valid", bb.out_valid, 3'b001);
    chk("bad_final_src", bb.out_src, 0);

    // reset in the middle of a message from input 3
    do_reset();
    ba.out_ready = 4'hF;
    set_a(3, 1, 2'd1, 0, 28'd1);
    #1;
    chk("mrst_chosen3", cho_a, 3);
    step();
    set_a(3, 1, 2'd1, 0, 28'd2);
    #1;
    chk("mrst_src3", ba.out_src, 3);
    step();
    reset = 1'b0;
    set_a(3, 1, 2'd1, 0, 28'd3);
    #1;
    chk("mrst_valid0", ba.out_valid, 0);
    chk("mrst_ready0", ba.in_ready, 0);
    chk("mrst_chosen0", cho_a, 0);
    chk("mrst_src0", ba.out_src, 0);
    set_a(0, 1, 2'd2, 1, 28'd9);
    step();
    chk("mrst_valid_hold", ba.out_valid, 0);
    reset = 1'b1;
    #1;
    chk("mrst_fresh_chosen", cho_a, 0);
    chk("mrst_fresh_ready", ba.in_ready, 4'b0001);
    step();
    chk("mrst_out_src", ba.out_src, 0);
    chk("mrst_out_valid", ba.out_valid, 4'b0100);
    chk("mrst_out_payload", ba.out_payload, 9);

    // random traffic on the 8-input instance with a scoreboard
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sent[i] = 0; rcvd[i] = 0; left[i] = 0; v[i] = 0; dstm[i] = 1'b0;
    end
    open_src = -1;
    done = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      for (int i = 0; i < 8; i++) begin
        if (!v[i] && sent[i] < 20 && $urandom_range(0, 3) != 0) begin
          v[i] = 1;
          if (left[i] == 0) begin
            left[i] = $urandom_range(1, 3);
            if (left[i] > 20 - sent[i]) left[i] = 20 - sent[i];
            dstm[i] = 1'($urandom_range(0, 1));
          end
        end
        pl = '0;
        pl[63:56] = 8'(i);
        pl[55:40] = 16'(sent[i]);
        pl[32] = (left[i] == 1);
        bc.in_valid[i] = v[i];
        bc.in_dst[i] = dstm[i];
        bc.in_last[i] = (left[i] == 1);
        bc.in_payload[i*64 +: 64] = pl;
      end
      bc.out_ready = 2'($urandom_range(0, 3));
      #1;
      acc = bc.in_valid & bc.in_ready;
      if ($countones(bc.in_ready) > 1) chk("rnd_one_ready", $countones(bc.in_ready), 1);
      if (|(bc.out_valid & bc.out_ready)) begin
        s = int'(bc.out_payload[63:56]);
        chk("rnd_src", bc.out_src, s);
        chk("rnd_onehot", bc.out_valid, 2'b01 << bc.out_dst);
        chk("rnd_last", bc.out_last, bc.out_payload[32]);
        if (open_src >= 0) chk("rnd_interleave", s, open_src);
        if (s < 8) begin
          chk("rnd_seq", bc.out_payload[55:40], rcvd[s]);
          rcvd[s]++;
        end
        open_src = bc.out_last ? -1 : s;
      end
      for (int i = 0; i < 8; i++) begin
        if (acc[i]) begin
          sent[i]++;
          left[i]--;
          v[i] = 0;
        end
      end
      done = 1;
      for (int i = 0; i < 8; i++)
        if (sent[i] < 20 || rcvd[i] < 20) done = 0;
      step();
    end
    for (int i = 0; i < 8; i++) chk("rnd_count", rcvd[i], 20);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
